// File: rtl/rs_wide.sv
// rs_wide: per-FU partitioned reservation station with multi-lane dispatch, CDB wakeup, oldest-first issue.
// Build option RS_WB_BYPASS_EN: same-cycle writeback sets ready bits on lanes being dispatched.

package rs_wide_pkg;
    localparam int unsigned FU_NUM  = 2;
    localparam int unsigned FU_W    = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
    localparam int unsigned PHYS_W  = 6;
    localparam int unsigned ROB_W   = 5;
    localparam int unsigned EPOCH_W = 2;

    localparam logic [FU_W-1:0] FU_ALU = FU_W'(0);
    localparam logic [FU_W-1:0] FU_LSU = FU_W'(1);

    typedef enum logic [1:0] {UcAlu, UcMul, UcLoad, UcStore} uop_class_e;

    typedef struct packed {
        uop_class_e uop_class;
        logic [7:0] imm;
    } bundle_t;

    typedef struct packed {
        bundle_t              bundle;
        logic                 uses_rs1;
        logic                 uses_rs2;
        logic                 rdy1;
        logic                 rdy2;
        logic [PHYS_W-1:0]    prs1;
        logic [PHYS_W-1:0]    prs2;
        logic [PHYS_W-1:0]    pd;
        logic [ROB_W-1:0]     rob_idx;
        logic [EPOCH_W-1:0]   epoch;
    } rs_uop_t;

    function automatic logic [FU_W-1:0] uop_to_fu(uop_class_e c);
        logic [FU_W-1:0] fu;
        unique case (c)
            UcAlu, UcMul:    fu = FU_ALU;
            UcLoad, UcStore: fu = FU_LSU;
            default:         fu = FU_ALU;
        endcase
        return fu;
    endfunction
endpackage

module rs_wide
    import rs_wide_pkg::*;
#(
    parameter int unsigned RS_SIZE   = 16,
    parameter int unsigned DISP_W    = 2,
    parameter int unsigned WB_PORTS  = 2,
    localparam int unsigned RS_PER_FU = (RS_SIZE + FU_NUM - 1) / FU_NUM,
    localparam int unsigned CNT_W     = $clog2(RS_PER_FU + 1),
    localparam int unsigned IDX_W     = (RS_PER_FU > 1) ? $clog2(RS_PER_FU) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DISP_W-1:0]                  disp_valid,
    output logic                               disp_ready,
    input  rs_uop_t [DISP_W-1:0]               disp_uop,
    input  logic [WB_PORTS-1:0]                wb_valid,
    input  logic [WB_PORTS-1:0][PHYS_W-1:0]    wb_pd,
    output logic [FU_NUM-1:0]                  issue_valid,
    input  logic [FU_NUM-1:0]                  issue_ready,
    output rs_uop_t [FU_NUM-1:0]               issue_uop,
    input  logic                               flush_valid,
    input  logic                               recover_valid,
    input  logic [ROB_W-1:0]                   recover_rob_idx,
    input  logic [EPOCH_W-1:0]                 recover_epoch,
    output logic                               busy,
    output logic [FU_NUM-1:0][CNT_W-1:0]       free_cnt
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RS_PER_FU);

    logic [FU_NUM-1:0][RS_PER_FU-1:0] valid_q, valid_d;
    rs_uop_t                          entry_q [FU_NUM][RS_PER_FU];
    rs_uop_t                          entry_d [FU_NUM][RS_PER_FU];
    logic [FU_NUM-1:0][CNT_W-1:0]     free_cnt_q, free_d;
    logic [FU_NUM-1:0]                sel_found;
    logic [FU_NUM-1:0][IDX_W-1:0]     sel_idx;
    logic                             squash;

    assign squash   = flush_valid | recover_valid;
    assign busy     = |valid_q;
    assign free_cnt = free_cnt_q;

    function automatic logic is_ready(rs_uop_t u);
        return (!u.uses_rs1 || u.rdy1) && (!u.uses_rs2 || u.rdy2);
    endfunction

    function automatic logic is_older(rs_uop_t a, rs_uop_t b);
        return (a.epoch < b.epoch) || ((a.epoch == b.epoch) && (a.rob_idx < b.rob_idx));
    endfunction

    // Oldest ready entry per partition, chosen purely from registered state.
    always_comb begin
        sel_found = '0;
        sel_idx   = '0;
        for (int f = 0; f < FU_NUM; f++) begin
            for (int i = 0; i < RS_PER_FU; i++) begin
                if (valid_q[f][i] && is_ready(entry_q[f][i]) &&
                    (!sel_found[f] || is_older(entry_q[f][i], entry_q[f][sel_idx[f]]))) begin
                    sel_found[f] = 1'b1;
                    sel_idx[f]   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        issue_valid = '0;
        issue_uop   = '0;
        for (int f = 0; f < FU_NUM; f++) begin
            issue_valid[f] = sel_found[f] & ~squash;
            issue_uop[f]   = entry_q[f][sel_idx[f]];
        end
    end

    // Whole group is accepted only if every partition can absorb its lanes.
    always_comb begin
        int unsigned need;
        need       = 0;
        disp_ready = ~squash;
        for (int f = 0; f < FU_NUM; f++) begin
            need = 0;
            for (int l = 0; l < DISP_W; l++) begin
                if (disp_valid[l] && (uop_to_fu(disp_uop[l].bundle.uop_class) == FU_W'(f))) begin
                    need = need + 1;
                end
            end
            if (need > 32'(free_cnt_q[f])) begin
                disp_ready = 1'b0;
            end
        end
    end

    always_comb begin
        logic [FU_NUM-1:0][RS_PER_FU-1:0] taken;
        logic                             placed;
        rs_uop_t                          lane_uop;
        valid_d  = valid_q;
        entry_d  = entry_q;
        taken    = valid_q;
        placed   = 1'b0;
        lane_uop = '0;
        free_d   = '0;
        if (flush_valid) begin
            valid_d = '0;
        end else begin
            for (int f = 0; f < FU_NUM; f++) begin
                for (int i = 0; i < RS_PER_FU; i++) begin
                    for (int p = 0; p < WB_PORTS; p++) begin
                        if (valid_q[f][i] && wb_valid[p]) begin
                            if (entry_q[f][i].uses_rs1 && (entry_q[f][i].prs1 == wb_pd[p])) begin
                                entry_d[f][i].rdy1 = 1'b1;
                            end
                            if (entry_q[f][i].uses_rs2 && (entry_q[f][i].prs2 == wb_pd[p])) begin
                                entry_d[f][i].rdy2 = 1'b1;
                            end
                        end
                    end
                    if (recover_valid && valid_q[f][i] &&
                        ((entry_q[f][i].epoch > recover_epoch) ||
                         ((entry_q[f][i].epoch == recover_epoch) &&
                          (entry_q[f][i].rob_idx > recover_rob_idx)))) begin
                        valid_d[f][i] = 1'b0;
                    end
                end
                if (issue_valid[f] && issue_ready[f]) begin
                    valid_d[f][sel_idx[f]] = 1'b0;
                end
            end
            if (disp_ready) begin
                for (int l = 0; l < DISP_W; l++) begin
                    lane_uop = disp_uop[l];
`ifdef RS_WB_BYPASS_EN
                    for (int p = 0; p < WB_PORTS; p++) begin
                        if (wb_valid[p] && (lane_uop.prs1 == wb_pd[p])) lane_uop.rdy1 = 1'b1;
                        if (wb_valid[p] && (lane_uop.prs2 == wb_pd[p])) lane_uop.rdy2 = 1'b1;
                    end
`endif
                    placed = 1'b0;
                    for (int f = 0; f < FU_NUM; f++) begin
                        for (int i = 0; i < RS_PER_FU; i++) begin
                            if (disp_valid[l] && !placed && !taken[f][i] &&
                                (uop_to_fu(lane_uop.bundle.uop_class) == FU_W'(f))) begin
                                taken[f][i]   = 1'b1;
                                placed        = 1'b1;
                                valid_d[f][i] = 1'b1;
                                entry_d[f][i] = lane_uop;
                            end
                        end
                    end
                end
            end
        end
        for (int f = 0; f < FU_NUM; f++) begin
            for (int i = 0; i < RS_PER_FU; i++) begin
                free_d[f] = free_d[f] + CNT_W'(~valid_d[f][i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            free_cnt_q <= {FU_NUM{FULL_CNT}};
        end else begin
            valid_q    <= valid_d;
            free_cnt_q <= free_d;
        end
    end

    // Payloads are qualified by valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule
